// File: rtl/interface_arb_pkg.sv
// Shared types for interface_arbiter: requester ids, FSM states and the buffered command.
// Width macros INTERFACE_DATA_WIDTH / INTERFACE_ADDR_WIDTH may be predefined by the build.
`ifndef INTERFACE_DATA_WIDTH
`define INTERFACE_DATA_WIDTH 16
`endif
`ifndef INTERFACE_ADDR_WIDTH
`define INTERFACE_ADDR_WIDTH 12
`endif

package interface_arb_pkg;

  localparam int ARB_DW = `INTERFACE_DATA_WIDTH;
  localparam int ARB_AW = `INTERFACE_ADDR_WIDTH;

  typedef enum logic {REQ_SPI, REQ_QSPI} req_id_t;
  typedef enum logic {ARB_IDLE, ARB_WAIT_RD} arb_state_t;

  typedef struct packed {
    logic              is_rd;
    logic [ARB_AW-1:0] addr;
    logic [ARB_DW-1:0] wdata;
  } cmd_t;

  // wen wins over ren when both are pulsed together
  function automatic cmd_t make_cmd(input logic wen, input logic ren,
                                    input logic [ARB_AW-1:0] addr,
                                    input logic [ARB_DW-1:0] wdata);
    cmd_t c;
    c.is_rd = ren & ~wen;
    c.addr  = addr;
    c.wdata = wdata;
    return c;
  endfunction

endpackage

// File: rtl/interface_cmd_slot.sv
// One-deep command buffer for a single requester: capture, drop detection, busy,
// and free-on-grant (a grant and a new capture may land on the same edge).
module interface_cmd_slot
  import interface_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic              ren,
  input  logic [ARB_AW-1:0] addr,
  input  logic [ARB_DW-1:0] wdata,
  input  logic              free,
  output logic              busy,
  output cmd_t              cmd,
  output logic              drop
);

  logic valid;
  logic req;
  logic take;

  assign req  = wen | ren;
  assign take = req & (~valid | free);
  assign busy = valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      cmd   <= '0;
      drop  <= 1'b0;
    end else begin
      if (take) begin
        valid <= 1'b1;
        cmd   <= make_cmd(wen, ren, addr, wdata);
      end else if (free) begin
        valid <= 1'b0;
      end
      drop <= (req & ~take) | (wen & ren);
    end
  end

endmodule

// File: rtl/interface_arbiter.sv
// Shares the array interface bus between SPI and QSPI requesters with one outstanding read.
// Define INTERFACE_ARB_RR_EN for round-robin arbitration; default is fixed SPI priority.
//
//   state       | meaning
//   ARB_IDLE    | issue one buffered command per cycle, writes back-to-back
//   ARB_WAIT_RD | read outstanding, waiting for if_rvalid or timeout
`ifndef INTERFACE_DATA_WIDTH
`define INTERFACE_DATA_WIDTH 16
`endif
`ifndef INTERFACE_ADDR_WIDTH
`define INTERFACE_ADDR_WIDTH 12
`endif

module interface_arbiter
  import interface_arb_pkg::*;
#(
  parameter int DW             = `INTERFACE_DATA_WIDTH,
  parameter int AW             = `INTERFACE_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] spi_addr,
  input  logic          spi_wen,
  input  logic          spi_ren,
  input  logic [DW-1:0] spi_wdata,
  output logic [DW-1:0] spi_rdata,
  output logic          spi_rvalid,
  output logic          spi_busy,
  input  logic [AW-1:0] qspi_addr,
  input  logic          qspi_wen,
  input  logic          qspi_ren,
  input  logic [DW-1:0] qspi_wdata,
  output logic [DW-1:0] qspi_rdata,
  output logic          qspi_rvalid,
  output logic          qspi_busy,
  output logic [AW-1:0] if_addr,
  output logic          if_wen,
  output logic [DW-1:0] if_wdata,
  output logic          if_ren,
  input  logic [DW-1:0] if_rdata,
  input  logic          if_rvalid,
  output logic          rd_timeout,
  output logic          cmd_drop
);

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t  state;
  req_id_t     owner;
  logic [15:0] timer;
  cmd_t        spi_cmd, qspi_cmd, gnt_cmd;
  logic        spi_drop, qspi_drop;
  logic        grant_spi, grant_qspi, prio_spi;

  interface_cmd_slot u_spi_slot (
    .clk(clk), .rst(rst), .wen(spi_wen), .ren(spi_ren), .addr(spi_addr),
    .wdata(spi_wdata), .free(grant_spi), .busy(spi_busy), .cmd(spi_cmd), .drop(spi_drop)
  );

  interface_cmd_slot u_qspi_slot (
    .clk(clk), .rst(rst), .wen(qspi_wen), .ren(qspi_ren), .addr(qspi_addr),
    .wdata(qspi_wdata), .free(grant_qspi), .busy(qspi_busy), .cmd(qspi_cmd), .drop(qspi_drop)
  );

`ifdef INTERFACE_ARB_RR_EN
  req_id_t last_grant;
  assign prio_spi = (last_grant == REQ_QSPI);
`else
  assign prio_spi = 1'b1;
`endif

  assign grant_spi  = (state == ARB_IDLE) & spi_busy & (~qspi_busy | prio_spi);
  assign grant_qspi = (state == ARB_IDLE) & qspi_busy & ~grant_spi;
  assign gnt_cmd    = grant_spi ? spi_cmd : qspi_cmd;
  assign cmd_drop   = spi_drop | qspi_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      owner       <= REQ_QSPI;
      timer       <= '0;
      if_addr     <= '0;
      if_wdata    <= '0;
      if_wen      <= 1'b0;
      if_ren      <= 1'b0;
      spi_rdata   <= '0;
      spi_rvalid  <= 1'b0;
      qspi_rdata  <= '0;
      qspi_rvalid <= 1'b0;
      rd_timeout  <= 1'b0;
`ifdef INTERFACE_ARB_RR_EN
      last_grant  <= REQ_QSPI;
`endif
    end else begin
      if_wen      <= 1'b0;
      if_ren      <= 1'b0;
      spi_rvalid  <= 1'b0;
      qspi_rvalid <= 1'b0;
      rd_timeout  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_spi | grant_qspi) begin
            if_addr  <= gnt_cmd.addr;
            if_wdata <= gnt_cmd.wdata;
`ifdef INTERFACE_ARB_RR_EN
            last_grant <= grant_spi ? REQ_SPI : REQ_QSPI;
`endif
            if (gnt_cmd.is_rd) begin
              if_ren <= 1'b1;
              state  <= ARB_WAIT_RD;
              owner  <= grant_spi ? REQ_SPI : REQ_QSPI;
              timer  <= '0;
            end else begin
              if_wen <= 1'b1;
            end
          end
        end
        ARB_WAIT_RD: begin
          // data arriving on the last timer cycle takes precedence over the timeout
          if (if_rvalid || timer == TIMER_LAST) begin
            if (owner == REQ_SPI) begin
              spi_rdata  <= if_rvalid ? if_rdata : '0;
              spi_rvalid <= 1'b1;
            end else begin
              qspi_rdata  <= if_rvalid ? if_rdata : '0;
              qspi_rvalid <= 1'b1;
            end
            rd_timeout <= ~if_rvalid;
            state      <= ARB_IDLE;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interface_arbiter.sv
// Scoreboard bench for interface_arbiter: directed stimulus pushes expected bus strobes,
// read deliveries and drops; negedge monitors pop and compare with exact cycle numbers.
module tb_interface_arbiter;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] spi_addr = '0, qspi_addr = '0;
  logic          spi_wen = 1'b0, spi_ren = 1'b0, qspi_wen = 1'b0, qspi_ren = 1'b0;
  logic [DW-1:0] spi_wdata = '0, qspi_wdata = '0, if_rdata = '0;
  logic          if_rvalid = 1'b0;
  logic [DW-1:0] spi_rdata, qspi_rdata, if_wdata;
  logic          spi_rvalid, qspi_rvalid, spi_busy, qspi_busy;
  logic [AW-1:0] if_addr;
  logic          if_wen, if_ren, rd_timeout, cmd_drop;

  interface_arbiter #(.DW(DW), .AW(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .spi_addr(spi_addr), .spi_wen(spi_wen), .spi_ren(spi_ren), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_rvalid(spi_rvalid), .spi_busy(spi_busy),
    .qspi_addr(qspi_addr), .qspi_wen(qspi_wen), .qspi_ren(qspi_ren), .qspi_wdata(qspi_wdata),
    .qspi_rdata(qspi_rdata), .qspi_rvalid(qspi_rvalid), .qspi_busy(qspi_busy),
    .if_addr(if_addr), .if_wen(if_wen), .if_wdata(if_wdata), .if_ren(if_ren),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid), .rd_timeout(rd_timeout), .cmd_drop(cmd_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic rd; logic [AW-1:0] addr; logic [DW-1:0] wdata; int cyc; } bus_exp_t;
  typedef struct { logic is_qspi; logic [DW-1:0] data; logic to; int cyc; } resp_exp_t;

  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];
  int        drop_q[$];
  int        n_cmp = 0;
  int        n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_bus(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    bus_exp_t e;
    e.rd = rd; e.addr = a; e.wdata = d; e.cyc = c;
    bus_q.push_back(e);
  endtask

  task automatic push_resp(input logic q, input logic [DW-1:0] d, input logic to, input int c);
    resp_exp_t e;
    e.is_qspi = q; e.data = d; e.to = to; e.cyc = c;
    resp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_flags"}, {if_wen, if_ren, spi_rvalid, qspi_rvalid, rd_timeout, cmd_drop, spi_busy, qspi_busy}, 0);
    check({tag, "_if_addr"}, 32'(if_addr), 0);
    check({tag, "_if_wdata"}, 32'(if_wdata), 0);
    check({tag, "_spi_rdata"}, 32'(spi_rdata), 0);
    check({tag, "_qspi_rdata"}, 32'(qspi_rdata), 0);
  endtask

  // bus strobe monitor
  always @(negedge clk) begin
    if (if_wen || if_ren) begin
      check("bus_strobe_expected", 32'(bus_q.size() != 0), 1);
      if (bus_q.size() != 0) begin
        bus_exp_t e;
        e = bus_q.pop_front();
        check("bus_cycle", cyc, e.cyc);
        check("bus_ren", 32'(if_ren), 32'(e.rd));
        check("bus_wen", 32'(if_wen), 32'(!e.rd));
        check("bus_addr", 32'(if_addr), 32'(e.addr));
        if (!e.rd) check("bus_wdata", 32'(if_wdata), 32'(e.wdata));
      end
    end
  end

  // read delivery monitor
  always @(negedge clk) begin
    if (spi_rvalid || qspi_rvalid || rd_timeout) begin
      check("resp_expected", 32'(resp_q.size() != 0), 1);
      if (resp_q.size() != 0) begin
        resp_exp_t e;
        e = resp_q.pop_front();
        check("resp_cycle", cyc, e.cyc);
        check("resp_spi_rvalid", 32'(spi_rvalid), 32'(!e.is_qspi));
        check("resp_qspi_rvalid", 32'(qspi_rvalid), 32'(e.is_qspi));
        check("resp_rdata", 32'(e.is_qspi ? qspi_rdata : spi_rdata), 32'(e.data));
        check("resp_timeout", 32'(rd_timeout), 32'(e.to));
      end
    end
  end

  // drop monitor
  always @(negedge clk) begin
    if (cmd_drop) begin
      check("drop_expected", 32'(drop_q.size() != 0), 1);
      if (drop_q.size() != 0) check("drop_cycle", cyc, drop_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    goto(3);
    check_reset_state("reset");
    rst = 1'b0;
    goto(5);

    // single SPI write, two-cycle latency
    t = cyc;
    spi_wen = 1; spi_addr = 12'h012; spi_wdata = 16'hBEEF;
    push_bus(0, 12'h012, 16'hBEEF, t + 2);
    goto(t + 1); spi_wen = 0;
    goto(t + 4);

    // simultaneous SPI read and QSPI write
    t = cyc;
    spi_ren = 1; spi_addr = 12'h020;
    qspi_wen = 1; qspi_addr = 12'h030; qspi_wdata = 16'h1234;
`ifdef INTERFACE_ARB_RR_EN
    push_bus(0, 12'h030, 16'h1234, t + 2);
    push_bus(1, 12'h020, 16'h0, t + 3);
`else
    push_bus(1, 12'h020, 16'h0, t + 2);
`endif
    push_resp(0, 16'hCAFE, 0, t + 5);
`ifndef INTERFACE_ARB_RR_EN
    push_bus(0, 12'h030, 16'h1234, t + 6);
`endif
    goto(t + 1); spi_ren = 0; qspi_wen = 0;
    goto(t + 4); if_rvalid = 1; if_rdata = 16'hCAFE;
    goto(t + 5); if_rvalid = 0;
    goto(t + 8);

    // QSPI read with a stray if_rvalid while idle
    t = cyc;
    qspi_ren = 1; qspi_addr = 12'h044;
    if_rvalid = 1; if_rdata = 16'h1111;
    push_bus(1, 12'h044, 16'h0, t + 2);
    push_resp(1, 16'h5A5A, 0, t + 7);
    goto(t + 1); qspi_ren = 0; if_rvalid = 0;
    goto(t + 6); if_rvalid = 1; if_rdata = 16'h5A5A;
    goto(t + 7); if_rvalid = 0;
    goto(t + 9);

    // SPI read times out, queued QSPI write issues right after
    t = cyc;
    spi_ren = 1; spi_addr = 12'h050;
    push_bus(1, 12'h050, 16'h0, t + 2);
    push_resp(0, 16'h0, 1, t + 10);
    push_bus(0, 12'h060, 16'h7777, t + 11);
    goto(t + 1); spi_ren = 0; qspi_wen = 1; qspi_addr = 12'h060; qspi_wdata = 16'h7777;
    goto(t + 2); qspi_wen = 0;
    goto(t + 13);

    // drops: full slot during read, then wen&ren together
    t = cyc;
    spi_ren = 1; spi_addr = 12'h070;
    push_bus(1, 12'h070, 16'h0, t + 2);
    goto(t + 1); spi_ren = 0;
    goto(t + 2); spi_wen = 1; spi_addr = 12'h080; spi_wdata = 16'hAAAA;
    goto(t + 3); spi_addr = 12'h090; spi_wdata = 16'hBBBB;
    check("busy_while_wait", 32'(spi_busy), 1);
    drop_q.push_back(t + 4);
    goto(t + 4); spi_wen = 0;
    goto(t + 5); if_rvalid = 1; if_rdata = 16'h0F0F;
    push_resp(0, 16'h0F0F, 0, t + 6);
    push_bus(0, 12'h080, 16'hAAAA, t + 7);
    goto(t + 6); if_rvalid = 0;
    goto(t + 8); spi_wen = 1; spi_ren = 1; spi_addr = 12'h0A0; spi_wdata = 16'hCCCC;
    drop_q.push_back(t + 9);
    push_bus(0, 12'h0A0, 16'hCCCC, t + 10);
    goto(t + 9); spi_wen = 0; spi_ren = 0;
    goto(t + 12);

    // reset during WAIT_RD, late if_rvalid ignored, fresh write afterwards
    t = cyc;
    qspi_ren = 1; qspi_addr = 12'h0B0;
    push_bus(1, 12'h0B0, 16'h0, t + 2);
    goto(t + 1); qspi_ren = 0;
    goto(t + 3); rst = 1;
    goto(t + 4); check_reset_state("midread_reset");
    goto(t + 5); rst = 0;
    goto(t + 6); if_rvalid = 1; if_rdata = 16'hDEAD;
    goto(t + 7); if_rvalid = 0;
    goto(t + 8); spi_wen = 1; spi_addr = 12'h0C0; spi_wdata = 16'h4321;
    push_bus(0, 12'h0C0, 16'h4321, t + 10);
    goto(t + 9); spi_wen = 0;
    goto(t + 14);

    check("bus_q_drained", bus_q.size(), 0);
    check("resp_q_drained", resp_q.size(), 0);
    check("drop_q_drained", drop_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
